// File: rtl/inv_matvec_apply.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | inv_matvec_apply: x = Ainv * b for a resident 5x5 inverse, one shared   |
// | MAC, streamed b in and x out over valid/ready.                          |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module inv_matvec_apply #(
    parameter int N      = 5,
    parameter int COEF_W = 64,
    parameter int DATA_W = 32,
    parameter int OUT_W  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N*N*COEF_W-1:0]    coef_flat,
    input  logic                     coef_load,
    output logic                     coef_ok,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [DATA_W-1:0]        b_data,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic [OUT_W-1:0]         y_data,
    output logic                     y_sat,
    output logic                     busy
);

    localparam int c_acc_w  = COEF_W + DATA_W + 3;
    localparam int c_prod_w = COEF_W + DATA_W;
    localparam int c_cnt_w  = $clog2(N);
    localparam int c_k_w    = $clog2(N*N);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N-1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_B = 2'd1,
        S_MAC    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [COEF_W-1:0]          r_coef [N*N];
    logic [DATA_W-1:0]          r_b    [N];
    logic [OUT_W-1:0]           r_ybuf [N];
    logic [N-1:0]               r_satbuf;
    logic [c_cnt_w-1:0]         r_cnt, r_idx, r_row, r_col;
    logic [c_k_w-1:0]           r_k;
    logic signed [c_acc_w-1:0]  r_acc;
    logic                       r_coef_ok;

    logic                       w_b_hs, w_y_hs, w_coef_take;
    logic                       w_last_b, w_last_y, w_col_last, w_mac_done;
    logic [COEF_W-1:0]          w_coef_sel;
    logic [DATA_W-1:0]          w_b_sel;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_acc_w-1:0]  w_prod_x, w_sum;
    logic                       w_fits;
    logic [OUT_W-1:0]           w_y_val;

    assign w_b_hs      = b_valid && (r_state == S_LOAD_B);
    assign w_y_hs      = y_ready && (r_state == S_DRAIN);
    // A new inverse may only replace the old one between vectors.
    assign w_coef_take = coef_load &&
                         ((r_state == S_IDLE) || ((r_state == S_LOAD_B) && (r_cnt == '0)));
    assign w_last_b    = w_b_hs && (r_cnt == c_last);
    assign w_last_y    = w_y_hs && (r_idx == c_last);
    assign w_col_last  = (r_col == c_last);
    assign w_mac_done  = (r_state == S_MAC) && w_col_last && (r_row == c_last);

    assign w_coef_sel = r_coef[r_k];
    assign w_b_sel    = r_b[r_col];
    assign w_prod     = $signed({{DATA_W{w_coef_sel[COEF_W-1]}}, w_coef_sel}) *
                        $signed({{COEF_W{w_b_sel[DATA_W-1]}}, w_b_sel});
    assign w_prod_x   = {{(c_acc_w-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
    assign w_sum      = (r_col == '0) ? w_prod_x : (r_acc + w_prod_x);
    // Fits in OUT_W when every bit above the output sign bit matches it.
    assign w_fits     = (&w_sum[c_acc_w-1:OUT_W-1]) | (~|w_sum[c_acc_w-1:OUT_W-1]);
    assign w_y_val    = w_fits ? w_sum[OUT_W-1:0] :
                        (w_sum[c_acc_w-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                          : {1'b0, {(OUT_W-1){1'b1}}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (coef_load)  w_state_nxt = S_LOAD_B;
            S_LOAD_B: if (w_last_b)   w_state_nxt = S_MAC;
            S_MAC:    if (w_mac_done) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_last_y)   w_state_nxt = S_LOAD_B;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N*N; i++) r_coef[i] <= '0;
            for (int i = 0; i < N; i++) begin
                r_b[i]    <= '0;
                r_ybuf[i] <= '0;
            end
            r_satbuf  <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_coef_ok <= 1'b0;
        end else begin
            if (w_coef_take) begin
                for (int i = 0; i < N*N; i++) r_coef[i] <= coef_flat[i*COEF_W +: COEF_W];
                r_coef_ok <= 1'b1;
            end
            if (w_b_hs) begin
                r_b[r_cnt] <= b_data;
                r_cnt      <= w_last_b ? '0 : r_cnt + 1'b1;
            end
            if (r_state == S_MAC) begin
                r_acc <= w_sum;
                r_k   <= w_mac_done ? '0 : r_k + 1'b1;
                if (w_col_last) begin
                    r_ybuf[r_row]   <= w_y_val;
                    r_satbuf[r_row] <= ~w_fits;
                    r_col           <= '0;
                    r_row           <= (r_row == c_last) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_y_hs) begin
                r_idx <= w_last_y ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign coef_ok = r_coef_ok;
    assign b_ready = (r_state == S_LOAD_B);
    assign y_valid = (r_state == S_DRAIN);
    assign busy    = (r_state == S_MAC) || (r_state == S_DRAIN);
    assign y_data  = (r_state == S_DRAIN) ? r_ybuf[r_idx] : '0;
    assign y_sat   = (r_state == S_DRAIN) && r_satbuf[r_idx];

endmodule
`default_nettype wire

// File: tb/tb_inv_matvec_apply.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_inv_matvec_apply: table vectors, corner sequences and random vectors |
// | checked against a wide-integer reference model.  Revision: 1.0          |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_inv_matvec_apply;

    localparam int N      = 5;
    localparam int COEF_W = 64;
    localparam int DATA_W = 32;
    localparam int OUT_W  = 64;

    typedef logic [N-1:0][DATA_W-1:0] bvec_t;
    typedef logic [N-1:0][OUT_W-1:0]  yvec_t;
    typedef struct {
        int           cset;
        bit           ld;
        bvec_t        b;
        yvec_t        y;
        logic [N-1:0] sat;
        int           hold_at;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N*N*COEF_W-1:0] coef_flat = '0;
    logic                  coef_load = 1'b0;
    logic                  b_valid = 1'b0;
    logic [DATA_W-1:0]     b_data = '0;
    logic                  y_ready = 1'b0;
    logic                  coef_ok, b_ready, y_valid, y_sat, busy;
    logic [OUT_W-1:0]      y_data;

    int n_checks = 0;
    int n_fail   = 0;

    longint cs_a[N*N];
    longint cs_s[N*N];
    longint cs_r[N*N];
    vec_t   tbl[5];

    inv_matvec_apply #(.N(N), .COEF_W(COEF_W), .DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .coef_flat(coef_flat), .coef_load(coef_load),
        .coef_ok(coef_ok), .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_sat(y_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // x = Ainv*b in 128-bit arithmetic, then clamped to the 64-bit signed range.
    function automatic void ref_model(input longint cf[N*N], input bvec_t b,
                                      output yvec_t y, output logic [N-1:0] s);
        logic signed [127:0] acc, hi, lo;
        hi = 128'sh7FFF_FFFF_FFFF_FFFF;
        lo = -hi - 128'sd1;
        for (int r = 0; r < N; r++) begin
            acc = '0;
            for (int c = 0; c < N; c++)
                acc += 128'(cf[r*N+c]) * 128'($signed(b[c]));
            if (acc > hi)      begin y[r] = hi[63:0]; s[r] = 1'b1; end
            else if (acc < lo) begin y[r] = lo[63:0]; s[r] = 1'b1; end
            else               begin y[r] = acc[63:0]; s[r] = 1'b0; end
        end
    endfunction

    function automatic vec_t mk(input int cset, input bit ld,
                                input int b0, input int b1, input int b2, input int b3, input int b4,
                                input longint y0, input longint y1, input longint y2,
                                input longint y3, input longint y4,
                                input logic [N-1:0] sat, input int hold_at);
        vec_t v;
        v.cset = cset; v.ld = ld; v.sat = sat; v.hold_at = hold_at;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
        v.y[0] = y0; v.y[1] = y1; v.y[2] = y2; v.y[3] = y3; v.y[4] = y4;
        return v;
    endfunction

    task automatic drive_coefs(input longint cf[N*N]);
        for (int i = 0; i < N*N; i++) coef_flat[i*COEF_W +: COEF_W] = cf[i];
    endtask

    task automatic send_b(input logic [DATA_W-1:0] v, input bit ld);
        int t;
        b_valid = 1'b1; b_data = v; coef_load = ld; t = 0;
        do begin @(negedge clk); t++; end while (!b_ready && t < 200);
        chk("b_ready_wait", b_ready, 1);
        @(posedge clk); #1;
        b_valid = 1'b0; coef_load = 1'b0;
    endtask

    task automatic recv_y(input yvec_t ey, input logic [N-1:0] es, input int hold_at);
        int t;
        bit bad;
        logic [OUT_W-1:0] hd;
        logic hs;
        for (int i = 0; i < N; i++) begin
            y_ready = (i != hold_at);
            t = 0; bad = 0;
            do begin
                @(negedge clk); t++;
                if (!y_valid && (b_ready || !busy)) bad = 1;
            end while (!y_valid && t < 200);
            if (i == 0) begin
                chk("latency_cycles", 64'(t), 64'd26);
                chk("mac_ready_busy", bad, 0);
            end
            chk("y_valid", y_valid, 1);
            if (i == hold_at) begin
                hd = y_data; hs = y_sat; bad = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (!y_valid || y_data !== hd || y_sat !== hs) bad = 1;
                end
                chk("hold_stable", bad, 0);
                y_ready = 1'b1;
            end
            chk($sformatf("y_data[%0d]", i), y_data, ey[i]);
            chk($sformatf("y_sat[%0d]", i), y_sat, es[i]);
            chk("drain_ready_busy", {b_ready, busy}, 2'b01);
            @(posedge clk); #1;
            y_ready = 1'b0;
        end
    endtask

    task automatic run_vec(input bvec_t b, input bit ld, input yvec_t ey,
                           input logic [N-1:0] es, input int hold_at);
        send_b(b[0], ld);
        for (int i = 1; i < N; i++) send_b(b[i], 1'b0);
        recv_y(ey, es, hold_at);
    endtask

    initial begin
        bvec_t            bv;
        yvec_t            ey;
        logic [N-1:0]     es;

        cs_a = '{1, 0, 0, 0, 0,   -3, 1, 0, 0, 0,   22, -9, 1, 0, 0,
                 -48, 20, -3, 0, 0,   -230, 94, -12, 0, 1};
        for (int i = 0; i < N*N; i++) cs_s[i] = (i < N) ? 64'h4000_0000_0000_0000 : 0;

        tbl[0] = mk(0, 0, 1, 2, 3, 4, 5,      1, -1, 7, -17, -73, 5'b00000, -1);
        tbl[1] = mk(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0,      5'b00000, -1);
        tbl[2] = mk(0, 0, -1, 0, 0, 0, 0,     -1, 3, -22, 48, 230, 5'b00000, 2);
        tbl[3] = mk(1, 1, 4, 4, 4, 4, 4,      64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 5'b00001, -1);
        tbl[4] = mk(1, 0, -4, -4, -4, -4, -4, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 5'b00001, -1);

        // Reset state, and b_valid ignored while no coefficients are resident.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {coef_ok, b_ready, y_valid, y_sat, busy}, 5'b0);
        chk("rst_y_data", y_data, 0);
        @(negedge clk); rst_n = 1'b1;
        b_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_b_ready", {b_ready, coef_ok}, 2'b00);
        b_valid = 1'b0;

        drive_coefs(cs_a);
        @(posedge clk); #1; coef_load = 1'b1;
        @(posedge clk); #1; coef_load = 1'b0;
        @(negedge clk);
        chk("load_ready_ok", {b_ready, coef_ok}, 2'b11);
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            if (tbl[v].ld) drive_coefs(tbl[v].cset == 0 ? cs_a : cs_s);
            run_vec(tbl[v].b, tbl[v].ld, tbl[v].y, tbl[v].sat, tbl[v].hold_at);
        end

        // Coincident reload back to A, then a reload mid-vector that must be ignored.
        drive_coefs(cs_a);
        run_vec(tbl[0].b, 1'b1, tbl[0].y, tbl[0].sat, -1);
        send_b(tbl[0].b[0], 1'b0);
        send_b(tbl[0].b[1], 1'b0);
        drive_coefs(cs_s);
        coef_load = 1'b1;
        @(posedge clk); #1; coef_load = 1'b0;
        for (int i = 2; i < N; i++) send_b(tbl[0].b[i], 1'b0);
        recv_y(tbl[0].y, tbl[0].sat, -1);
        run_vec(tbl[3].b, 1'b1, tbl[3].y, tbl[3].sat, -1);

        // Asynchronous reset in MAC cycle 12.
        for (int i = 0; i < N; i++) send_b(tbl[0].b[i], 1'b0);
        repeat (12) @(negedge clk);
        chk("mac_busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {coef_ok, b_ready, y_valid, y_sat, busy}, 5'b0);
        chk("rst_mid_y_data", y_data, 0);
        @(negedge clk); rst_n = 1'b1;
        b_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", {b_ready, coef_ok, busy}, 3'b000);
        b_valid = 1'b0;
        drive_coefs(cs_a);
        @(posedge clk); #1; coef_load = 1'b1;
        @(posedge clk); #1; coef_load = 1'b0;
        run_vec(tbl[0].b, 1'b0, tbl[0].y, tbl[0].sat, -1);

        // Random coefficient/vector sets, mixing small and full-range values.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N*N; i++)
                cs_r[i] = (v % 2 == 1) ? longint'({$urandom, $urandom})
                                       : longint'(int'($urandom_range(2000, 0)) - 1000);
            for (int i = 0; i < N; i++)
                bv[i] = (v % 4 >= 2) ? $urandom : DATA_W'(int'($urandom_range(200, 0)) - 100);
            ref_model(cs_r, bv, ey, es);
            drive_coefs(cs_r);
            run_vec(bv, 1'b1, ey, es, (v == 5) ? 4 : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
